// File: rtl/alu_issue_pkg.sv
// Shared constants and types for the single-issue ALU block.
package alu_issue_pkg;

  localparam logic [3:0] OP_ADD = 4'b1000;
  localparam logic [3:0] OP_SUB = 4'b0100;
  localparam logic [3:0] OP_MUL = 4'b0010;
  localparam logic [3:0] OP_DIV = 4'b0001;

  localparam int unsigned DIV_ITERS = 32;
  localparam int unsigned DIV_CNT_W = $clog2(DIV_ITERS);

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXEC,
    S_DIV,
    S_RESP
  } state_e;

endpackage

// File: rtl/alu_issue_if.sv
// Request/response handshake bundle between a requester and alu_issue.
interface alu_issue_if;

  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_rs;
  logic [31:0] req_rt;
  logic [3:0]  req_op;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rd;
  logic        resp_dz;
  logic        resp_illegal;

  modport master (
    output req_valid, req_rs, req_rt, req_op, resp_ready,
    input  req_ready, resp_valid, resp_rd, resp_dz, resp_illegal
  );

  modport slave (
    input  req_valid, req_rs, req_rt, req_op, resp_ready,
    output req_ready, resp_valid, resp_rd, resp_dz, resp_illegal
  );

endinterface

// File: rtl/alu_issue_alu.sv
// Combinational add/sub/mul unit; any non-sub/mul opcode computes add.
module alu_issue_alu
  import alu_issue_pkg::*;
(
  input  logic [31:0] rs,
  input  logic [31:0] rt,
  input  logic [3:0]  op,
  output logic [31:0] rd
);

  // Select the operation; results wrap to the low 32 bits.
  always_comb begin
    rd = rs + rt;
    case (op)
      OP_SUB:  rd = rs - rt;
      OP_MUL:  rd = rs * rt;
      default: rd = rs + rt;
    endcase
  end

endmodule

// File: rtl/alu_issue.sv
// Single-issue ALU with valid/ready handshakes and a 32-cycle restoring divider.
module alu_issue
  import alu_issue_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  alu_issue_if.slave   bus
);

  state_e                 state_q;
  logic                   exec_stage_q;
  logic [31:0]            rs_q;
  logic [31:0]            rt_q;
  logic [3:0]             op_q;
  logic [31:0]            alu_q;
  logic [31:0]            div_quo_q;
  logic [31:0]            div_rem_q;
  logic [DIV_CNT_W-1:0]   div_cnt_q;
  logic                   req_ready_q;
  logic                   resp_valid_q;
  logic [31:0]            resp_rd_q;
  logic                   resp_dz_q;
  logic                   resp_illegal_q;

  logic [31:0]            alu_rd;
  logic [32:0]            rem_shift;
  logic [32:0]            rem_diff;
  logic                   div_take;
  logic [31:0]            rem_next;
  logic [31:0]            quo_next;
  logic                   op_is_div;
  logic                   op_legal;

  alu_issue_alu u_alu (
    .rs (rs_q),
    .rt (rt_q),
    .op (op_q),
    .rd (alu_rd)
  );

  // Opcode decode of the registered request.
  always_comb begin
    op_is_div = (op_q == OP_DIV);
    op_legal  = (op_q == OP_ADD) || (op_q == OP_SUB) ||
                (op_q == OP_MUL) || (op_q == OP_DIV);
  end

  // One restoring-division step: shift in the next dividend bit, subtract if no borrow.
  always_comb begin
    rem_shift = {div_rem_q, div_quo_q[31]};
    rem_diff  = rem_shift - {1'b0, rt_q};
    div_take  = ~rem_diff[32];
    rem_next  = div_take ? rem_diff[31:0] : rem_shift[31:0];
    quo_next  = {div_quo_q[30:0], div_take};
  end

  // Control FSM with registered handshake and response outputs.
  // EXEC spends two cycles: the first latches the ALU result, the second
  // routes to DIV or RESP, giving the fixed two-edge response latency.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= S_IDLE;
      exec_stage_q   <= 1'b0;
      rs_q           <= '0;
      rt_q           <= '0;
      op_q           <= '0;
      alu_q          <= '0;
      div_quo_q      <= '0;
      div_rem_q      <= '0;
      div_cnt_q      <= '0;
      req_ready_q    <= 1'b1;
      resp_valid_q   <= 1'b0;
      resp_rd_q      <= '0;
      resp_dz_q      <= 1'b0;
      resp_illegal_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.req_valid && req_ready_q) begin
            rs_q         <= bus.req_rs;
            rt_q         <= bus.req_rt;
            op_q         <= bus.req_op;
            exec_stage_q <= 1'b0;
            req_ready_q  <= 1'b0;
            state_q      <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (!exec_stage_q) begin
            alu_q        <= alu_rd;
            exec_stage_q <= 1'b1;
          end else if (op_is_div && (rt_q != '0)) begin
            div_quo_q <= rs_q;
            div_rem_q <= '0;
            div_cnt_q <= '0;
            state_q   <= S_DIV;
          end else begin
            resp_valid_q   <= 1'b1;
            resp_rd_q      <= op_is_div ? '1 : alu_q;
            resp_dz_q      <= op_is_div;
            resp_illegal_q <= ~op_legal;
            state_q        <= S_RESP;
          end
        end
        S_DIV: begin
          div_rem_q <= rem_next;
          div_quo_q <= quo_next;
          div_cnt_q <= div_cnt_q + 1'b1;
          if (div_cnt_q == DIV_CNT_W'(DIV_ITERS - 1)) begin
            resp_valid_q   <= 1'b1;
            resp_rd_q      <= quo_next;
            resp_dz_q      <= 1'b0;
            resp_illegal_q <= 1'b0;
            state_q        <= S_RESP;
          end
        end
        S_RESP: begin
          if (bus.resp_ready) begin
            resp_valid_q <= 1'b0;
            req_ready_q  <= 1'b1;
            state_q      <= S_IDLE;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.req_ready    = req_ready_q;
  assign bus.resp_valid   = resp_valid_q;
  assign bus.resp_rd      = resp_rd_q;
  assign bus.resp_dz      = resp_dz_q;
  assign bus.resp_illegal = resp_illegal_q;

endmodule

// File: tb/tb_alu_issue.sv
// Self-checking bench for alu_issue: directed vector table, reset corner
// cases, and randomized operations against a behavioural model.
module tb_alu_issue;

  logic clk;
  logic rst;
  int   n_pass;
  int   n_total;

  alu_issue_if bus ();

  alu_issue dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [3:0]  op;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [31:0] e_rd;
    logic        e_dz;
    logic        e_ill;
    int          e_lat;
    int          hold;
  } vec_t;

  typedef struct {
    logic [31:0] rd;
    logic        dz;
    logic        ill;
    int          lat;
  } exp_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Behavioural model: what the answer and latency should be for one request.
  function automatic exp_t model(input logic [3:0] op, input logic [31:0] rs, input logic [31:0] rt);
    exp_t e;
    e.dz = 1'b0; e.ill = 1'b0; e.lat = 2;
    case (op)
      4'b1000: e.rd = rs + rt;
      4'b0100: e.rd = rs - rt;
      4'b0010: e.rd = 32'((64'(rs) * 64'(rt)) % 64'h1_0000_0000);
      4'b0001: begin
        if (rt == 0) begin e.rd = 32'hFFFF_FFFF; e.dz = 1'b1; end
        else begin e.rd = rs / rt; e.lat = 34; end
      end
      default: begin e.rd = rs + rt; e.ill = 1'b1; end
    endcase
    return e;
  endfunction

  // Issue one request, measure latency, hold off the consumer, then complete.
  task automatic run_op(input string name, input logic [3:0] op, input logic [31:0] rs,
                        input logic [31:0] rt, input logic [31:0] e_rd, input logic e_dz,
                        input logic e_ill, input int e_lat, input int hold);
    int guard;
    int lat;
    bit stable;
    guard = 0;
    while (!bus.req_ready && guard < 200) begin @(posedge clk); #1; guard++; end
    chk({name, " ready-before-issue"}, 32'(bus.req_ready), 32'd1);
    bus.req_valid = 1'b1;
    bus.req_op    = op;
    bus.req_rs    = rs;
    bus.req_rt    = rt;
    @(posedge clk); #1;
    // Garbage on the request side while busy must be ignored.
    bus.req_valid = 1'b1;
    bus.req_op    = 4'($urandom);
    bus.req_rs    = $urandom;
    bus.req_rt    = $urandom;
    lat = 0;
    while (!bus.resp_valid && lat < 100) begin @(posedge clk); #1; lat++; end
    chk({name, " latency"}, 32'(lat), 32'(e_lat));
    stable = 1'b1;
    for (int i = 0; i < hold; i++) begin
      if (bus.resp_rd !== e_rd || bus.resp_dz !== e_dz || bus.resp_illegal !== e_ill ||
          bus.req_ready !== 1'b0 || bus.resp_valid !== 1'b1) stable = 1'b0;
      @(posedge clk); #1;
    end
    if (hold > 0) chk({name, " stable-while-stalled"}, 32'(stable), 32'd1);
    chk({name, " rd"}, bus.resp_rd, e_rd);
    chk({name, " dz"}, 32'(bus.resp_dz), 32'(e_dz));
    chk({name, " illegal"}, 32'(bus.resp_illegal), 32'(e_ill));
    chk({name, " ready-in-handshake"}, 32'(bus.req_ready), 32'd0);
    bus.req_valid  = 1'b0;
    bus.resp_ready = 1'b1;
    @(posedge clk); #1;
    bus.resp_ready = 1'b0;
    chk({name, " after-handshake"}, {30'd0, bus.resp_valid, bus.req_ready}, 32'd1);
  endtask

  task automatic chk_reset_outputs(input string name);
    chk({name, " req_ready"}, 32'(bus.req_ready), 32'd1);
    chk({name, " resp_valid"}, 32'(bus.resp_valid), 32'd0);
    chk({name, " resp_rd"}, bus.resp_rd, 32'd0);
    chk({name, " flags"}, {30'd0, bus.resp_dz, bus.resp_illegal}, 32'd0);
  endtask

  vec_t vecs[$];
  exp_t e;

  initial begin
    n_pass = 0;
    n_total = 0;
    rst = 1'b1;
    bus.req_valid = 1'b1;
    bus.req_op = 4'b1000;
    bus.req_rs = 32'd1;
    bus.req_rt = 32'd1;
    bus.resp_ready = 1'b0;

    // Reset held with req_valid high: nothing may be accepted.
    repeat (3) @(posedge clk);
    #1;
    chk_reset_outputs("reset");
    rst = 1'b0;
    bus.req_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_outputs("post-reset-idle");

    vecs.push_back('{"add7+5",   4'b1000, 32'd7,        32'd5,       32'd12,        1'b0, 1'b0, 2,  0});
    vecs.push_back('{"sub0-1",   4'b0100, 32'd0,        32'd1,       32'hFFFF_FFFF, 1'b0, 1'b0, 2,  0});
    vecs.push_back('{"mulwrap",  4'b0010, 32'h1_0000,   32'h1_0000,  32'd0,         1'b0, 1'b0, 2,  0});
    vecs.push_back('{"div100/7", 4'b0001, 32'd100,      32'd7,       32'd14,        1'b0, 1'b0, 34, 0});
    vecs.push_back('{"div5/0",   4'b0001, 32'd5,        32'd0,       32'hFFFF_FFFF, 1'b1, 1'b0, 2,  0});
    vecs.push_back('{"ill0011",  4'b0011, 32'd2,        32'd3,       32'd5,         1'b0, 1'b1, 2,  0});
    vecs.push_back('{"ill0000",  4'b0000, 32'd10,       32'd20,      32'd30,        1'b0, 1'b1, 2,  0});
    vecs.push_back('{"divmax/1", 4'b0001, 32'hFFFF_FFFF, 32'd1,      32'hFFFF_FFFF, 1'b0, 1'b0, 34, 0});
    vecs.push_back('{"div3/10",  4'b0001, 32'd3,        32'd10,      32'd0,         1'b0, 1'b0, 34, 0});
    vecs.push_back('{"divbig",   4'b0001, 32'hFFFF_FFFF, 32'h8000_0000, 32'd1,      1'b0, 1'b0, 34, 3});
    vecs.push_back('{"hold10",   4'b0100, 32'd50,       32'd8,       32'd42,        1'b0, 1'b0, 2,  10});
    vecs.push_back('{"mul3x7",   4'b0010, 32'd3,        32'd7,       32'd21,        1'b0, 1'b0, 2,  1});

    foreach (vecs[i])
      run_op(vecs[i].name, vecs[i].op, vecs[i].rs, vecs[i].rt, vecs[i].e_rd,
             vecs[i].e_dz, vecs[i].e_ill, vecs[i].e_lat, vecs[i].hold);

    // Reset in the middle of a division: no response, then a clean divide.
    begin
      int seen;
      bus.req_valid = 1'b1;
      bus.req_op = 4'b0001;
      bus.req_rs = 32'd1000;
      bus.req_rt = 32'd7;
      @(posedge clk); #1;
      bus.req_valid = 1'b0;
      repeat (2 + 15) @(posedge clk);
      #1;
      chk("middiv busy", {30'd0, bus.resp_valid, bus.req_ready}, 32'd0);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      chk_reset_outputs("middiv-reset");
      seen = 0;
      for (int i = 0; i < 40; i++) begin
        if (bus.resp_valid) seen++;
        @(posedge clk); #1;
      end
      chk("middiv no-response", 32'(seen), 32'd0);
      run_op("div9/3", 4'b0001, 32'd9, 32'd3, 32'd3, 1'b0, 1'b0, 34, 0);
    end

    // Randomized operations against the model.
    for (int n = 0; n < 40; n++) begin
      logic [3:0]  op;
      logic [31:0] rs;
      logic [31:0] rt;
      int sel;
      sel = $urandom_range(0, 5);
      case (sel)
        0: op = 4'b1000;
        1: op = 4'b0100;
        2: op = 4'b0010;
        3, 4: op = 4'b0001;
        default: op = 4'($urandom);
      endcase
      rs = $urandom;
      case ($urandom_range(0, 3))
        0: rt = 32'd0;
        1: rt = 32'($urandom_range(1, 255));
        default: rt = $urandom;
      endcase
      e = model(op, rs, rt);
      run_op("rand", op, rs, rt, e.rd, e.dz, e.ill, e.lat, $urandom_range(0, 3));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
